// File: rtl/pmem_line_arbiter.sv
// pmem_line_arbiter: serialises one-outstanding-per-port cache line reads and
// writes from NUM_PORTS L1 channels onto a single line-wide physical memory
// port. Selection is round-robin or fixed priority. The winning request is
// latched for the whole memory transaction, and the response is returned to
// the granted port only.
module pmem_line_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int RR_MODE    = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             port_read,
  input  logic [NUM_PORTS-1:0]             port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  port_wdata,
  output logic [NUM_PORTS-1:0]             port_resp,
  output logic [LINE_WIDTH-1:0]            port_rdata,
  output logic [NUM_PORTS-1:0]             port_error,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic [LINE_WIDTH-1:0]            pmem_wdata,
  input  logic                             pmem_resp,
  input  logic [LINE_WIDTH-1:0]            pmem_rdata,
  input  logic                             pmem_error
);

  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic                    op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [NUM_PORTS-1:0]    req;
  logic                    any_req;
  logic [GW-1:0]           win;
  logic [GW-1:0]           cand;
  logic                    found;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [LINE_WIDTH-1:0]   win_wdata;

  // A port with both read and write set is treated as a write.
  assign req     = port_read | port_write;
  assign any_req = |req;

  // Winner selection: rotating search after the last grant, or lowest index.
  always_comb begin
    win   = '0;
    cand  = last_grant_q;
    found = 1'b0;
    if (RR_MODE != 0) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
        if (!found && req[cand]) begin
          win   = cand;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req[i]) begin
          win = GW'(i);
        end
      end
    end
  end

  // Route the winning port's address and write line toward the latches.
  always_comb begin
    win_addr  = port_address[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
    win_wdata = port_wdata[int'(win)*LINE_WIDTH +: LINE_WIDTH];
  end

  // State and transaction registers; data is cleared too so idle outputs are 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_IDX;
      op_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_wr_q      <= op_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic: grant in IDLE, wait for memory in BUSY, one-cycle RESP.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_wr_d      = op_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d      = S_BUSY;
          grant_d      = win;
          last_grant_d = win;
          op_wr_d      = port_write[win];
          addr_d       = win_addr;
          wdata_d      = win_wdata;
        end
      end
      S_BUSY: begin
        // Port inputs are deliberately not looked at here; the latched copy rules.
        if (pmem_resp) begin
          state_d = S_RESP;
          rdata_d = pmem_rdata;
          err_d   = pmem_error;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode only registered state, so no input reaches an output directly.
  always_comb begin
    pmem_read    = (state_q == S_BUSY) && !op_wr_q;
    pmem_write   = (state_q == S_BUSY) && op_wr_q;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    port_rdata   = rdata_q;
    port_resp    = '0;
    port_error   = '0;
    if (state_q == S_RESP) begin
      port_resp[grant_q]  = 1'b1;
      port_error[grant_q] = err_q;
    end
  end

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Directed bench for pmem_line_arbiter: a 2-port round-robin instance and a
// 4-port fixed-priority instance, with memory responses driven by hand.
module tb_pmem_line_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // 2-port round-robin instance
  logic [1:0]   p_read, p_write, p_resp, p_err;
  logic [63:0]  p_addr;
  logic [511:0] p_wdata;
  logic [255:0] p_rdata, m_wdata, m_rdata;
  logic         m_read, m_write, m_resp, m_error;
  logic [31:0]  m_addr;

  pmem_line_arbiter #(.NUM_PORTS(2), .LINE_WIDTH(256), .ADDR_WIDTH(32), .RR_MODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .port_read(p_read), .port_write(p_write), .port_address(p_addr), .port_wdata(p_wdata),
    .port_resp(p_resp), .port_rdata(p_rdata), .port_error(p_err),
    .pmem_read(m_read), .pmem_write(m_write), .pmem_address(m_addr), .pmem_wdata(m_wdata),
    .pmem_resp(m_resp), .pmem_rdata(m_rdata), .pmem_error(m_error)
  );

  // 4-port fixed-priority instance
  logic [3:0]   q_read, q_write, q_resp, q_err;
  logic [127:0] q_addr;
  logic [255:0] q_wdata;
  logic [63:0]  q_rdata, n_wdata, n_rdata;
  logic         n_read, n_write, n_resp, n_error;
  logic [31:0]  n_addr;

  pmem_line_arbiter #(.NUM_PORTS(4), .LINE_WIDTH(64), .ADDR_WIDTH(32), .RR_MODE(0)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .port_read(q_read), .port_write(q_write), .port_address(q_addr), .port_wdata(q_wdata),
    .port_resp(q_resp), .port_rdata(q_rdata), .port_error(q_err),
    .pmem_read(n_read), .pmem_write(n_write), .pmem_address(n_addr), .pmem_wdata(n_wdata),
    .pmem_resp(n_resp), .pmem_rdata(n_rdata), .pmem_error(n_error)
  );

  task automatic chk(input string tag, input logic [255:0] ob, input logic [255:0] ex);
    total++;
    assert (ob === ex) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, ob, ex);
  endtask

  // Wait (bounded) for the 2-port instance to raise a memory command.
  task automatic wait2(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_read || m_write) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 256'(0), 256'(1));
  endtask

  task automatic resp2(input string tag, input logic [1:0] eh, input logic [255:0] rd,
                       input logic er, input logic wr);
    m_resp = 1'b1; m_rdata = rd; m_error = er;
    @(negedge clk);
    m_resp = 1'b0; m_error = 1'b0;
    chk({tag, "_resp"}, 256'(p_resp), 256'(eh));
    chk({tag, "_err"}, 256'(p_err), er ? 256'(eh) : 256'(0));
    if (!wr) chk({tag, "_rdata"}, p_rdata, rd);
    chk({tag, "_cmd_off"}, 256'({m_read, m_write}), 256'(0));
  endtask

  task automatic wait4(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n_read || n_write) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 256'(0), 256'(1));
  endtask

  task automatic resp4(input string tag, input logic [3:0] eh, input logic [63:0] rd);
    n_resp = 1'b1; n_rdata = rd; n_error = 1'b0;
    @(negedge clk);
    n_resp = 1'b0;
    chk({tag, "_resp"}, 256'(q_resp), 256'(eh));
    chk({tag, "_err"}, 256'(q_err), 256'(0));
    chk({tag, "_rdata"}, 256'(q_rdata), 256'(rd));
    chk({tag, "_cmd_off"}, 256'({n_read, n_write}), 256'(0));
  endtask

  initial begin
    logic [255:0] d;
    rst_n = 1'b0;
    p_read = '0; p_write = '0; p_addr = '0; p_wdata = '0;
    m_resp = 1'b0; m_rdata = '0; m_error = 1'b0;
    q_read = '0; q_write = '0; q_addr = '0; q_wdata = '0;
    n_resp = 1'b0; n_rdata = '0; n_error = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_cmd", 256'({m_read, m_write}), 256'(0));
    chk("rst_resp", 256'({p_resp, p_err}), 256'(0));
    chk("rst_addr", 256'(m_addr), 256'(0));
    chk("rst_wdata", m_wdata, 256'(0));
    chk("rst_rdata", p_rdata, 256'(0));
    chk("rst4_cmd", 256'({n_read, n_write, q_resp, q_err}), 256'(0));

    // Single read from port 1, memory answers after 5 command cycles
    rst_n = 1'b1;
    p_read = 2'b10;
    p_addr[63:32] = 32'h0000_0060;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rd1_pmem_read", 256'({m_read, m_write}), 256'(2'b10));
      chk("rd1_addr", 256'(m_addr), 256'(32'h60));
      chk("rd1_no_resp", 256'(p_resp), 256'(0));
    end
    resp2("rd1", 2'b10, {8{32'hA5A5_A5A5}}, 1'b0, 1'b0);
    p_read = 2'b00;
    @(negedge clk);
    chk("rd1_resp_once", 256'(p_resp), 256'(0));
    chk("rd1_idle", 256'({m_read, m_write}), 256'(0));

    // Round-robin alternation after reset with both ports requesting
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    p_read = 2'b11;
    p_addr = {32'h0000_2000, 32'h0000_1000};
    for (int r = 0; r < 4; r++) begin
      wait2("rr");
      chk("rr_addr", 256'(m_addr), (r % 2 == 0) ? 256'(32'h1000) : 256'(32'h2000));
      resp2("rr", (r % 2 == 0) ? 2'b01 : 2'b10, {8{32'h1111_0000 + 32'(r)}}, 1'b0, 1'b0);
    end

    // Write from port 0; port inputs change while the write is in flight
    d = {8{32'hDEAD_BEEF}};
    p_read = 2'b00;
    p_write = 2'b01;
    p_addr[31:0] = 32'h0000_0100;
    p_wdata[255:0] = d;
    wait2("wr");
    p_addr[31:0] = 32'h0000_0200;
    p_wdata[255:0] = ~d;
    chk("wr_cmd", 256'({m_read, m_write}), 256'(2'b01));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_addr_hold", 256'(m_addr), 256'(32'h100));
      chk("wr_data_hold", m_wdata, d);
    end
    resp2("wr", 2'b01, '0, 1'b0, 1'b1);
    p_write = 2'b00;

    // Error path on a port 1 read
    p_read = 2'b10;
    p_addr[63:32] = 32'h0000_0300;
    wait2("errp");
    chk("errp_addr", 256'(m_addr), 256'(32'h300));
    resp2("errp", 2'b10, {8{32'h5A5A_0F0F}}, 1'b1, 1'b0);

    // Reset during BUSY, then a stray memory response
    p_read = 2'b01;
    p_addr[31:0] = 32'h0000_0400;
    wait2("rstb");
    chk("rstb_addr", 256'(m_addr), 256'(32'h400));
    @(negedge clk);
    chk("rstb_busy", 256'(m_read), 256'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstb_cmd_drop", 256'({m_read, m_write}), 256'(0));
    chk("rstb_no_resp", 256'(p_resp), 256'(0));
    rst_n = 1'b1;
    p_read = 2'b00;
    m_resp = 1'b1;
    @(negedge clk);
    m_resp = 1'b0;
    chk("rstb_stray_resp", 256'(p_resp), 256'(0));
    chk("rstb_stray_cmd", 256'({m_read, m_write}), 256'(0));
    p_read = 2'b11;
    p_addr = {32'h0000_0500, 32'h0000_0600};
    wait2("post");
    chk("post_addr_port0_first", 256'(m_addr), 256'(32'h600));
    resp2("post", 2'b01, {8{32'h0BAD_F00D}}, 1'b0, 1'b0);
    p_read = 2'b00;

    // Fixed priority, 4 ports: 1,2,3 together and port 1 re-requesting
    q_read = 4'b1110;
    q_addr = {32'h30, 32'h20, 32'h10, 32'h0};
    wait4("fp1");
    chk("fp1_addr", 256'(n_addr), 256'(32'h10));
    resp4("fp1", 4'b0010, 64'h1);
    wait4("fp1b");
    chk("fp1b_addr", 256'(n_addr), 256'(32'h10));
    resp4("fp1b", 4'b0010, 64'h2);
    q_read = 4'b1100;
    wait4("fp2");
    chk("fp2_addr", 256'(n_addr), 256'(32'h20));
    chk("fp2_wdata", 256'(n_wdata), 256'(0));
    resp4("fp2", 4'b0100, 64'h3);
    q_read = 4'b1000;
    wait4("fp3");
    chk("fp3_addr", 256'(n_addr), 256'(32'h30));
    resp4("fp3", 4'b1000, 64'h4);
    q_read = 4'b0000;

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
